// File: rtl/spu_pkg.sv
// Shared types for the SPU permute pipeline: operation codes, the pipeline
// depth and the 128-bit quadword type.
package spu_pkg;

    typedef enum logic [2:0] {
        ROT_W  = 3'd0,
        ROT_H  = 3'd1,
        SHL_W  = 3'd2,
        ROTQBY = 3'd3
    } perm_op_t;

    localparam int LATENCY = 4;

    typedef logic [127:0] quad_t;

endpackage

// File: rtl/rotate_unit.sv
// Combinational permute datapath: word/halfword rotates, word shift-left and
// whole-quadword byte rotate. Unused opcodes produce zero.
module rotate_unit
    import spu_pkg::*;
(
    input  logic [2:0]   op_sel,
    input  logic [127:0] register_RA,
    input  logic [127:0] register_RB,
    output logic [127:0] result
);

    function automatic logic [31:0] rotl32(input logic [31:0] w, input logic [4:0] n);
        logic [63:0] t;
        t = {w, w} << n;
        return t[63:32];
    endfunction

    function automatic logic [15:0] rotl16(input logic [15:0] h, input logic [3:0] n);
        logic [31:0] t;
        t = {h, h} << n;
        return t[31:16];
    endfunction

    // Bit 5 of the count means 32 or more, which always empties the word.
    function automatic logic [31:0] shl32(input logic [31:0] w, input logic [5:0] n);
        return n[5] ? 32'h0 : (w << n[4:0]);
    endfunction

    function automatic logic [127:0] rotqby(input logic [127:0] q, input logic [3:0] n);
        logic [255:0] t;
        t = {q, q} << {n, 3'b000};
        return t[255:128];
    endfunction

    // Only the low count bits of each RB lane take part in the operations.
    logic unused_rb;
    assign unused_rb = ^register_RB;

    always_comb begin
        result = '0;
        case (op_sel)
            ROT_W: begin
                for (int i = 0; i < 4; i++)
                    result[32*i +: 32] = rotl32(register_RA[32*i +: 32], register_RB[32*i +: 5]);
            end
            ROT_H: begin
                for (int j = 0; j < 8; j++)
                    result[16*j +: 16] = rotl16(register_RA[16*j +: 16], register_RB[16*j +: 4]);
            end
            SHL_W: begin
                for (int i = 0; i < 4; i++)
                    result[32*i +: 32] = shl32(register_RA[32*i +: 32], register_RB[32*i +: 6]);
            end
            ROTQBY: result = rotqby(register_RA, register_RB[3:0]);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/permute_pipe.sv
// Four-stage permute pipeline: S1 captures the operands, the rotate unit
// computes into S2, S3/S4 delay, and S4 drives the writeback port.
module permute_pipe
    import spu_pkg::quad_t;
#(
    parameter int LATENCY = 4,
    parameter int ADDR_W  = 7
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              issue_valid,
    input  logic [2:0]        op_sel,
    input  logic [127:0]      register_RA,
    input  logic [127:0]      register_RB,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic              stall,
    input  logic              flush,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_rt_addr,
    output logic [127:0]      register_RT
);

    if (LATENCY != spu_pkg::LATENCY) begin : g_latency_unsupported
        $error("permute_pipe: only LATENCY=4 is supported");
    end

    // S1 holds the raw operands (RA, RB and opcode) ahead of the rotate unit.
    logic              s1_valid;
    logic [ADDR_W-1:0] s1_addr;
    logic [2:0]        s1_op;
    quad_t             s1_ra;
    quad_t             s1_rb;

    logic              s2_valid, s3_valid, s4_valid;
    logic [ADDR_W-1:0] s2_addr, s3_addr, s4_addr;
    quad_t             s2_data, s3_data, s4_data;

    quad_t             rot_result;

    rotate_unit u_rotate_unit (
        .op_sel      (s1_op),
        .register_RA (s1_ra),
        .register_RB (s1_rb),
        .result      (rot_result)
    );

    // Flush outranks stall; it only kills valids, payload may go stale.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_op    <= '0;
            s1_ra    <= '0;
            s1_rb    <= '0;
            s2_valid <= 1'b0;
            s2_addr  <= '0;
            s2_data  <= '0;
            s3_valid <= 1'b0;
            s3_addr  <= '0;
            s3_data  <= '0;
            s4_valid <= 1'b0;
            s4_addr  <= '0;
            s4_data  <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            s4_valid <= 1'b0;
        end else if (!stall) begin
            s1_valid <= issue_valid;
            s1_addr  <= rt_addr;
            s1_op    <= op_sel;
            s1_ra    <= register_RA;
            s1_rb    <= register_RB;
            s2_valid <= s1_valid;
            s2_addr  <= s1_addr;
            s2_data  <= rot_result;
            s3_valid <= s2_valid;
            s3_addr  <= s2_addr;
            s3_data  <= s2_data;
            s4_valid <= s3_valid;
            s4_addr  <= s3_addr;
            s4_data  <= s3_data;
        end
    end

    assign wb_valid    = s4_valid;
    assign wb_rt_addr  = s4_addr;
    assign register_RT = s4_data;

endmodule

// File: tb/tb_permute_pipe.sv
// Directed bench for permute_pipe with an expected-writeback queue keyed by
// the unstalled-edge count at which each result must appear.
module tb_permute_pipe;

    localparam int ADDR_W = 7;
    localparam int EW     = 32 + ADDR_W + 128;

    typedef logic [127:0] quad_t;

    logic              clk;
    logic              reset_n;
    logic              issue_valid;
    logic [2:0]        op_sel;
    quad_t             register_RA;
    quad_t             register_RB;
    logic [ADDR_W-1:0] rt_addr;
    logic              stall;
    logic              flush;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_rt_addr;
    quad_t             register_RT;

    int checks;
    int failures;
    int ucnt;
    logic [EW-1:0] exp_q[$];

    permute_pipe #(.LATENCY(4), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .issue_valid (issue_valid),
        .op_sel      (op_sel),
        .register_RA (register_RA),
        .register_RB (register_RB),
        .rt_addr     (rt_addr),
        .stall       (stall),
        .flush       (flush),
        .wb_valid    (wb_valid),
        .wb_rt_addr  (wb_rt_addr),
        .register_RT (register_RT)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic quad_t model(input logic [2:0] op, input quad_t ra, input quad_t rb);
        quad_t r;
        int n;
        r = '0;
        case (op)
            3'd0: for (int w = 0; w < 4; w++) begin
                n = int'(rb[32*w +: 5]);
                for (int b = 0; b < 32; b++) r[32*w + ((b + n) % 32)] = ra[32*w + b];
            end
            3'd1: for (int h = 0; h < 8; h++) begin
                n = int'(rb[16*h +: 4]);
                for (int b = 0; b < 16; b++) r[16*h + ((b + n) % 16)] = ra[16*h + b];
            end
            3'd2: for (int w = 0; w < 4; w++) begin
                n = int'(rb[32*w +: 6]);
                for (int b = 0; b < 32; b++) if (b + n < 32) r[32*w + b + n] = ra[32*w + b];
            end
            3'd3: begin
                n = int'(rb[3:0]);
                for (int k = 0; k < 16; k++) r[8*((k + n) % 16) +: 8] = ra[8*k +: 8];
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_out();
        logic exp_v;
        logic [EW-1:0] e;
        exp_v = (exp_q.size() > 0) && (exp_q[0][EW-1 -: 32] == 32'(ucnt));
        chk("wb_valid", {255'b0, wb_valid}, {255'b0, exp_v});
        if (exp_v) begin
            e = exp_q.pop_front();
            if (wb_valid) begin
                chk("wb_rt_addr", {249'b0, wb_rt_addr}, {249'b0, e[128 +: ADDR_W]});
                chk("register_RT", {128'b0, register_RT}, {128'b0, e[127:0]});
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic tick(input logic iv, input logic [2:0] op, input quad_t a, input quad_t b,
                        input logic [ADDR_W-1:0] addr, input logic st, input logic fl);
        logic [ADDR_W+128:0] pre;
        issue_valid = iv;
        op_sel      = op;
        register_RA = a;
        register_RB = b;
        rt_addr     = addr;
        stall       = st;
        flush       = fl;
        pre = {wb_valid, wb_rt_addr, register_RT};
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
        end else if (!st) begin
            ucnt++;
            if (iv) exp_q.push_back({32'(ucnt + 3), addr, model(op, a, b)});
        end
        #1;
        if (fl)
            chk("flush_wb_valid", {255'b0, wb_valid}, 256'b0);
        else if (st)
            chk("stall_hold", {120'b0, wb_valid, wb_rt_addr, register_RT}, {120'b0, pre});
        else
            check_out();
        @(negedge clk);
        issue_valid = 1'b0;
        stall       = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 3'd0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    function automatic quad_t rnd_q();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        checks = 0;
        failures = 0;
        ucnt = 0;
        reset_n = 1'b0;
        issue_valid = 1'b0;
        op_sel = '0;
        register_RA = '0;
        register_RB = '0;
        rt_addr = '0;
        stall = 1'b0;
        flush = 1'b0;

        #12;
        chk("reset_wb_valid", {255'b0, wb_valid}, 256'b0);
        chk("reset_wb_rt_addr", {249'b0, wb_rt_addr}, 256'b0);
        chk("reset_register_RT", {128'b0, register_RT}, 256'b0);
        @(negedge clk);
        reset_n = 1'b1;

        // Single operations of each kind, with the literal corner values.
        tick(1'b1, 3'd0, {32'hdeadbeef, 32'h12345678, 32'h0f0f0f0f, 32'h8000_0001},
             {32'd31, 32'd8, 32'd4, 32'd1}, 7'd5, 1'b0, 1'b0);
        idle(4);
        tick(1'b1, 3'd1, {32'hcafef00d, 32'h0001_8000, 32'habcd_ef01, 32'h5555_1234},
             {32'h000f_0001, 32'h0001_000f, 32'h0008_0003, 32'h0010_0004}, 7'd6, 1'b0, 1'b0);
        tick(1'b1, 3'd2, {32'hffff_ffff, 32'h1234_5678, 32'hffff_ffff, 32'hffff_ffff},
             {32'h5, 32'h40, 32'd33, 32'd32}, 7'd7, 1'b0, 1'b0);
        tick(1'b1, 3'd3, 128'h00112233_44556677_8899AABB_CCDDEEFF, 128'h1, 7'd8, 1'b0, 1'b0);
        tick(1'b1, 3'd3, rnd_q(), 128'hf, 7'd9, 1'b0, 1'b0);
        tick(1'b1, 3'd5, rnd_q(), rnd_q(), 7'd10, 1'b0, 1'b0);
        idle(5);

        // Back-to-back random operations over all opcodes.
        for (int i = 0; i < 10; i++)
            tick(1'b1, 3'($urandom_range(0, 7)), rnd_q(), rnd_q(), 7'($urandom_range(0, 127)), 1'b0, 1'b0);
        idle(5);

        // Stall mid-stream and again while a writeback is on the outputs.
        tick(1'b1, 3'd0, rnd_q(), rnd_q(), 7'd1, 1'b0, 1'b0);
        tick(1'b1, 3'd1, rnd_q(), rnd_q(), 7'd2, 1'b0, 1'b0);
        tick(1'b1, 3'd2, rnd_q(), rnd_q(), 7'd99, 1'b1, 1'b0);
        tick(1'b1, 3'd2, rnd_q(), rnd_q(), 7'd98, 1'b1, 1'b0);
        tick(1'b1, 3'd2, rnd_q(), rnd_q(), 7'd3, 1'b0, 1'b0);
        tick(1'b1, 3'd3, rnd_q(), rnd_q(), 7'd4, 1'b0, 1'b0);
        idle(1);
        tick(1'b0, 3'd0, '0, '0, '0, 1'b1, 1'b0);
        tick(1'b1, 3'd0, rnd_q(), rnd_q(), 7'd97, 1'b1, 1'b0);
        idle(5);

        // Flush kills three in-flight ops and its own issue; the next issue survives.
        tick(1'b1, 3'd0, rnd_q(), rnd_q(), 7'd10, 1'b0, 1'b0);
        tick(1'b1, 3'd1, rnd_q(), rnd_q(), 7'd11, 1'b0, 1'b0);
        tick(1'b1, 3'd2, rnd_q(), rnd_q(), 7'd12, 1'b0, 1'b0);
        tick(1'b1, 3'd3, rnd_q(), rnd_q(), 7'd13, 1'b1, 1'b1);
        tick(1'b1, 3'd0, rnd_q(), rnd_q(), 7'd14, 1'b0, 1'b0);
        idle(6);

        // Asynchronous reset with operations in flight and a writeback showing.
        for (int i = 0; i < 5; i++)
            tick(1'b1, 3'd0, rnd_q(), {96'h0, 32'(i + 1)}, 7'(20 + i), 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_wb_valid", {255'b0, wb_valid}, 256'b0);
        chk("async_reset_wb_rt_addr", {249'b0, wb_rt_addr}, 256'b0);
        chk("async_reset_register_RT", {128'b0, register_RT}, 256'b0);
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        idle(6);
        tick(1'b1, 3'd3, 128'h00112233_44556677_8899AABB_CCDDEEFF, 128'h4, 7'd30, 1'b0, 1'b0);
        idle(5);

        chk("queue_empty", 256'(exp_q.size()), 256'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
